// File: rtl/image_pingpong_buffer_if.sv
// Producer/consumer bus for the image ping-pong buffer.
// The buffer uses the slave modport and the frame source/sink uses the master modport.
interface image_pingpong_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                         wr_valid;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic signed [DATA_WIDTH-1:0] wr_data;
    logic                         wr_last;
    logic                         wr_ready;
    logic                         rd_en;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic                         rd_release;
    logic                         frame_avail;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         rd_valid;
    logic                         addr_err;
    logic [7:0]                   frame_count;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_release,
        input  wr_ready, frame_avail, rd_data, rd_valid, addr_err, frame_count
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_release,
        output wr_ready, frame_avail, rd_data, rd_valid, addr_err, frame_count
    );
endinterface

// File: rtl/image_pingpong_buffer.sv
// Two-bank frame buffer: the writer fills one bank while the reader consumes the other.
// Banks swap ownership on commit (wr_last) and on release.
module image_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 784,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    image_pingpong_buffer_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

    logic signed [DATA_WIDTH-1:0] mem [2][DEPTH];

    logic                         wr_bank_q, wr_bank_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [1:0]                   full_q, full_d;
    logic signed [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                         rd_valid_q, rd_valid_d;
    logic                         addr_err_q, addr_err_d;
    logic [7:0]                   frame_count_q, frame_count_d;

    logic             wr_in_range, rd_in_range;
    logic             wr_fire, wr_accept, commit;
    logic             rd_fire, rd_accept, release_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign bus.wr_ready    = ~full_q[wr_bank_q];
    assign bus.frame_avail = full_q[rd_bank_q];
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.frame_count = frame_count_q;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_L;
    assign wr_idx      = bus.wr_addr[IDX_W-1:0];
    assign rd_idx      = bus.rd_addr[IDX_W-1:0];

    assign wr_fire    = bus.wr_valid & bus.wr_ready;
    assign wr_accept  = wr_fire & wr_in_range;
    assign commit     = wr_accept & bus.wr_last;
    assign rd_fire    = bus.rd_en & bus.frame_avail;
    assign rd_accept  = rd_fire & rd_in_range;
    assign release_ok = bus.rd_release & bus.frame_avail;

    always_comb begin
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        addr_err_d    = addr_err_q;
        frame_count_d = frame_count_q;

        // The read uses the pre-release bank, so a coincident release still returns this frame.
        if (rd_accept) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_bank_q][rd_idx];
        end
        if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range))
            addr_err_d = 1'b1;

        // Release is applied before commit so that a shared target bank ends up full.
        if (release_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            frame_count_d     = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            full_q        <= 2'b00;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            full_q        <= full_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            addr_err_q    <= addr_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    // The storage itself is never cleared; reset only blocks writes while it is held.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && wr_accept)
            mem[wr_bank_q][wr_idx] <= bus.wr_data;
    end
endmodule

// File: tb/tb_image_pingpong_buffer.sv
// Directed bench for image_pingpong_buffer.
// A frame-queue model is checked against the DUT every cycle, and literal checks pin the key points.
module tb_image_pingpong_buffer;
    localparam int DW = 32;
    localparam int DEPTH = 784;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    image_pingpong_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    image_pingpong_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: committed frames form a FIFO of bank numbers, and the reader always owns the oldest one.
    int     m_mem [2][DEPTH];
    int     m_q [$];
    int     m_wbank;
    bit     m_err;
    int     m_cnt;
    bit     m_rv;
    longint m_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_wbank = 0;
            m_err = 0;
            m_cnt = 0;
            m_rv = 0;
            m_rd = 0;
        end else begin
            bit avail;
            bit ready;
            int rb;
            int wa;
            int ra;
            avail = (m_q.size() > 0);
            ready = (m_q.size() < 2);
            rb = avail ? m_q[0] : 0;
            wa = int'(bus.wr_addr);
            ra = int'(bus.rd_addr);
            m_rv = 0;
            if (bus.rd_en && avail) begin
                if (ra < DEPTH) begin
                    m_rv = 1;
                    m_rd = m_mem[rb][ra];
                end else begin
                    m_err = 1;
                end
            end
            if (bus.rd_release && avail) void'(m_q.pop_front());
            if (bus.wr_valid && ready) begin
                if (wa < DEPTH) begin
                    m_mem[m_wbank][wa] = int'(bus.wr_data);
                    if (bus.wr_last) begin
                        m_q.push_back(m_wbank);
                        m_wbank ^= 1;
                        m_cnt++;
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("wr_ready", bus.wr_ready, (m_q.size() < 2));
        check("frame_avail", bus.frame_avail, (m_q.size() > 0));
        check("addr_err", bus.addr_err, m_err);
        check("frame_count", bus.frame_count, m_cnt % 256);
        check("rd_valid", bus.rd_valid, m_rv);
        check("rd_data", bus.rd_data, m_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.wr_valid = 0; bus.wr_last = 0; bus.rd_en = 0; bus.rd_release = 0;
    endtask

    task automatic wr(input int a, input int d, input bit last);
        bus.wr_valid = 1; bus.wr_addr = AW'(a); bus.wr_data = DW'(d); bus.wr_last = last;
        tick();
        clr();
    endtask

    task automatic rd(input int a);
        bus.rd_en = 1; bus.rd_addr = AW'(a);
        tick();
        clr();
    endtask

    initial begin
        clr();
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        tick(); tick();
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_frame_avail", bus.frame_avail, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_addr_err", bus.addr_err, 0);
        rst = 0;
        tick();

        // Frame 1 goes into bank 0.
        for (int a = 0; a < DEPTH; a++) wr(a, a - 100, a == DEPTH - 1);
        check("f1_avail", bus.frame_avail, 1);
        check("f1_ready", bus.wr_ready, 1);
        check("f1_count", bus.frame_count, 1);
        rd(5);
        check("f1_rv", bus.rd_valid, 1);
        check("f1_rd5", bus.rd_data, -95);
        tick();
        check("f1_rv_drop", bus.rd_valid, 0);

        // Frame 2 goes into bank 1, after which both banks are full.
        for (int a = 0; a < DEPTH; a++) wr(a, 3 * a + 1, a == DEPTH - 1);
        check("f2_ready", bus.wr_ready, 0);
        check("f2_count", bus.frame_count, 2);
        wr(0, 7, 1);
        check("blocked_count", bus.frame_count, 2);
        bus.rd_release = 1; tick(); clr();
        check("rel_ready", bus.wr_ready, 1);
        check("rel_avail", bus.frame_avail, 1);
        rd(0);
        check("f2_rd0", bus.rd_data, 1);
        rd(10);
        check("f2_rd10", bus.rd_data, 31);

        // Out-of-range write and read.
        wr(784, 55, 1);
        check("oob_err", bus.addr_err, 1);
        check("oob_count", bus.frame_count, 2);
        rd(900);
        check("oob_rv", bus.rd_valid, 0);
        check("oob_rd_hold", bus.rd_data, 31);
        check("oob_err_sticky", bus.addr_err, 1);

        // A commit and a release happen in the same cycle.
        for (int a = 1; a < 10; a++) wr(a, 500 + a, 0);
        bus.wr_valid = 1; bus.wr_addr = AW'(783); bus.wr_data = DW'(999); bus.wr_last = 1;
        bus.rd_release = 1;
        tick(); clr();
        check("cr_avail", bus.frame_avail, 1);
        check("cr_ready", bus.wr_ready, 1);
        check("cr_count", bus.frame_count, 3);
        rd(3);
        check("cr_rd3", bus.rd_data, 503);
        rd(0);
        check("cr_rd0_untouched", bus.rd_data, -100);
        rd(783);
        check("cr_rd783", bus.rd_data, 999);

        // A read and a release in the same cycle return data from the old bank.
        bus.rd_en = 1; bus.rd_addr = AW'(4); bus.rd_release = 1;
        tick(); clr();
        check("rr_rv", bus.rd_valid, 1);
        check("rr_rd4", bus.rd_data, 504);
        check("rr_avail", bus.frame_avail, 0);
        rd(6);
        check("noavail_rv", bus.rd_valid, 0);
        check("noavail_hold", bus.rd_data, 504);

        // Reset is asserted in the middle of a frame.
        for (int a = 0; a <= 300; a++) wr(a, 2000 + a, 0);
        rst = 1;
        #1;
        check("mid_rst_ready", bus.wr_ready, 1);
        check("mid_rst_avail", bus.frame_avail, 0);
        check("mid_rst_rv", bus.rd_valid, 0);
        check("mid_rst_count", bus.frame_count, 0);
        check("mid_rst_err", bus.addr_err, 0);
        bus.rd_en = 1; bus.rd_addr = AW'(5);
        tick(); clr();
        rst = 0;
        rd(5);
        check("post_rst_rv", bus.rd_valid, 0);
        wr(783, 42, 1);
        check("post_rst_count", bus.frame_count, 1);
        rd(5);
        check("retained_rd5", bus.rd_data, 505);
        rd(783);
        check("post_rst_rd783", bus.rd_data, 42);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/image_pingpong_buffer.md
IMAGE_PINGPONG_BUFFER -- requirements
Module: image_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed pixel word width.
REQ-002 SHALL have parameter DEPTH, default 784, words per frame bank.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, address port width; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_valid  input  1  write request.
REQ-007 SHALL have port wr_addr  input  ADDR_WIDTH  word address within current write bank.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH signed  write word.
REQ-009 SHALL have port wr_last  input  1  qualifies wr_valid; commits the write bank after this write.
REQ-010 SHALL have port wr_ready  output  1  write bank is free to accept writes.
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  word address within current read bank.
REQ-013 SHALL have port rd_release  input  1  consumer finished with the read bank.
REQ-014 SHALL have port frame_avail  output  1  read bank holds a committed frame.
REQ-015 SHALL have port rd_data  output  DATA_WIDTH signed  registered read word.
REQ-016 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-017 SHALL have port addr_err  output  1  sticky out-of-range access flag.
REQ-018 SHALL have port frame_count  output  8  committed frames, wrapping modulo 256.

Function
REQ-019 SHALL hold two banks of DEPTH x DATA_WIDTH words (bank 0, bank 1); state = wr_bank bit, rd_bank bit, full[1:0].
REQ-020 SHALL drive wr_ready = ~full[wr_bank], combinationally.
REQ-021 SHALL accept a write when wr_valid & wr_ready & wr_addr < DEPTH: mem[wr_bank][wr_addr] <= wr_data at the edge.
REQ-022 SHALL, on an accepted write with wr_last=1, set full[wr_bank], toggle wr_bank, increment frame_count, same edge.
REQ-023 SHALL ignore writes while wr_ready=0 (no memory change, no commit); not an error.
REQ-024 SHALL drive frame_avail = full[rd_bank], combinationally.
REQ-025 SHALL, on rd_en & frame_avail & rd_addr < DEPTH, register rd_data <= mem[rd_bank][rd_addr] and rd_valid <= 1 (1-cycle latency); otherwise rd_valid <= 0 and rd_data holds.
REQ-026 SHALL, on rd_release & frame_avail, clear full[rd_bank] and toggle rd_bank; rd_release with frame_avail=0 is ignored.
REQ-027 SHALL, when rd_en and rd_release coincide, return the read from the bank current before the toggle.
REQ-028 SHALL apply a commit and a release in the same cycle independently; when they target the same bank (one bank free only), release clears, then commit sets; net full=1 and both pointers toggle.
REQ-029 SHALL set addr_err on wr_valid&wr_ready with wr_addr >= DEPTH, or rd_en&frame_avail with rd_addr >= DEPTH; the write is dropped (including wr_last commit), the read gives rd_valid=0.
REQ-030 SHALL keep addr_err set until reset.
REQ-031 SHALL never have wr_bank == rd_bank with full[wr_bank]=1 while wr_ready=1 (bank ownership invariant).

Reset
REQ-032 SHALL, while rst=1 (asynchronously), force wr_bank=0, rd_bank=0, full=00, rd_valid=0, rd_data=0, addr_err=0, frame_count=0.
REQ-033 SHALL NOT clear memory contents on reset; a frame in progress is discarded logically (bank reported empty).
REQ-034 SHALL ignore all write, read and release requests while rst=1.

Verification
REQ-035 Write 784 words (data=addr-100) to bank 0, last on addr 783 -> frame_avail=1, wr_ready=1, frame_count=1; rd_en addr 5 -> next cycle rd_valid=1, rd_data=-95.
REQ-036 Commit two frames without release -> wr_ready=0; further write of 7 to addr 0 -> ignored; release -> wr_ready=1, frame_avail=1, read addr 0 returns frame 2 data.
REQ-037 wr_valid, wr_addr=784 -> addr_err=1 next cycle, memory unchanged; rd_en rd_addr=900 with frame_avail -> rd_valid=0, addr_err remains 1.
REQ-038 One bank full, other filling: commit with wr_last and rd_release in same cycle -> full=11 minus released bank, frame_avail=1, frame_count increments.
REQ-039 Assert rst mid-frame (addr 300 written) -> immediately wr_ready=1, frame_avail=0, rd_valid=0, frame_count=0; rd_en ignored until new commit.
REQ-040 rd_en with frame_avail=0 -> rd_valid=0, rd_data unchanged.
